led_pwm_driver: RTL and testbench
=================================

LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001: Parameter PRESCALE, default 196, number of clk cycles per PWM step (1..65535); 196 gives a PWM frame of about 1 kHz at 50 MHz.
REQ-002: clk  input  1  single system clock; all state is updated on its rising edge.
REQ-003: reset_n  input  1  asynchronous, active-low reset.
REQ-004: led_in  input  18  raw LED pattern from the LEDR PIO out_port (upstream stage).
REQ-005: address  input  2  Avalon-MM slave register select.
REQ-006: chipselect  input  1  Avalon-MM slave select.
REQ-007: write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008: writedata  input  32  Avalon-MM write data.
REQ-009: readdata  output  32  Avalon-MM read data, combinational, zero-extended.
REQ-010: led_out  output  18  registered drive to the board LEDs.

Function
REQ-011: A write is chipselect=1 and write_n=0, and it is taken on that clk edge with zero wait states.
REQ-012: Register map:
- addr0 DUTY[7:0], R/W
- addr1 BLINK_MASK[17:0], R/W
- addr2 BLINK_PERIOD[15:0], R/W
- addr3 STATUS, read-only: bit0 = blink_phase, bits15:8 = pwm_cnt, other bits 0
- Writes to addr3 are ignored.
REQ-013: Write data wider than a register is truncated to the register width; readdata bits above the register width read 0.
REQ-014: Prescaler counts 0..PRESCALE-1 and wraps; a step tick is asserted in the cycle it equals PRESCALE-1.
REQ-015: pwm_cnt is 8 bits and increments on each step tick, wrapping 255->0; the wrap is the frame end.
REQ-016: A DUTY write updates the DUTY shadow register immediately; the active duty copies the shadow only at frame end, so no partial frame is ever produced.
REQ-017: pwm_on = (active_duty == 8'hFF) OR (pwm_cnt < active_duty); duty 0 gives always off, duty 255 gives always on.
REQ-018: Blink engine, driven by a 16-bit frame counter:
- BLINK_PERIOD=0: blink disabled, blink_phase held at 1.
- Otherwise the frame counter increments at each frame end.
- When the counter equals BLINK_PERIOD-1 at a frame end, it clears and blink_phase toggles.
REQ-019: A BLINK_PERIOD write clears the frame counter and sets blink_phase=1 in the same cycle; the new period applies from the next frame end.
REQ-020: Per bit i: led_out[i] <= led_in[i] AND pwm_on AND (blink_phase OR NOT BLINK_MASK[i]).
REQ-021: Latency from led_in to led_out is exactly 1 clk; led_in is assumed synchronous to clk.
REQ-022: A BLINK_MASK write takes effect on led_out on the next clk, with no frame alignment.
REQ-023: If a BLINK_PERIOD write coincides with a frame end, the write wins: the counter is cleared and phase=1, with no toggle.
REQ-024: If a DUTY write coincides with a frame end, the newly written value becomes active_duty.

Reset
REQ-025: While reset_n=0:
- prescaler = 0, pwm_cnt = 0, frame counter = 0
- DUTY shadow = active duty = 8'hFF
- BLINK_MASK = 0, BLINK_PERIOD = 0, blink_phase = 1
- led_out = 0
REQ-026: After release, led_out mirrors led_in with 1-clk latency until software writes a register, making the block transparent by default.
REQ-027: Assertion of reset mid-frame or mid-blink clears all state at once, with no completion of the frame.

Verification
REQ-028: Reset release, led_in=18'h2AAAA, no writes -> led_out=18'h2AAAA one clk later; STATUS reads 1 in bit0.
REQ-029: PRESCALE=1, DUTY=64 -> after the next frame end, each LED with led_in=1 is high for exactly 64 of every 256 clk, starting at pwm_cnt=0.
REQ-030: DUTY=200 written mid-frame while active duty is 64 -> the current frame keeps 64 high cycles; the next frame has 200.
REQ-031: PRESCALE=1, BLINK_PERIOD=2, BLINK_MASK=18'h00001, DUTY=255, led_in=18'h3FFFF -> bit0 is on for 512 clk then off for 512 clk, repeating; bits17:1 stay constantly 1.
REQ-032: BLINK_PERIOD written on the exact frame-end cycle -> blink_phase=1 and the frame counter reads 0 next cycle, with no toggle; DUTY=0 -> led_out=0 regardless of led_in.
REQ-033: reset_n asserted while blink_phase=0 and pwm_cnt=130 -> led_out=0 at once, and STATUS reads 0x00000001 after release.

Source files
------------

// File: rtl/led_pwm_driver.sv
// led_pwm_driver
//   PWM dimmer and blinker placed between the LEDR PIO and the board LEDs.
//   Every LED is gated by a common PWM duty and, for LEDs selected in
//   BLINK_MASK, by a slow blink phase. A small Avalon-MM slave holds the
//   settings.
//
// Parameters
//   PRESCALE   clk cycles per PWM step (1..65535)
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   led_in       raw LED pattern from the upstream PIO
//   address      register select: 0 DUTY, 1 BLINK_MASK, 2 BLINK_PERIOD, 3 STATUS
//   chipselect   slave select
//   write_n      write strobe, active-low
//   writedata    write data
//   readdata     combinational, zero-extended read data
//   led_out      registered LED drive
module led_pwm_driver #(
   parameter int unsigned PRESCALE = 196
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [17:0] led_in,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [17:0] led_out
);

   localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

   logic [15:0] prescaler;
   logic [7:0]  pwm_cnt;
   logic [7:0]  duty_shadow;
   logic [7:0]  active_duty;
   logic [17:0] blink_mask;
   logic [15:0] blink_period;
   logic [15:0] frame_cnt;
   logic        blink_phase;

   logic        step_tick;
   logic        frame_end;
   logic        wr;
   logic        wr_duty;
   logic        wr_mask;
   logic        wr_period;
   logic        pwm_on;
   logic [17:0] blink_gate;
   logic        unused_wdata;

   always_comb begin
      step_tick    = (prescaler == PRESCALE_LAST);
      frame_end    = step_tick && (pwm_cnt == 8'hFF);
      wr           = chipselect && !write_n;
      wr_duty      = wr && (address == 2'd0);
      wr_mask      = wr && (address == 2'd1);
      wr_period    = wr && (address == 2'd2);
      pwm_on       = (active_duty == 8'hFF) || (pwm_cnt < active_duty);
      // Blinking LEDs are forced off only during the off phase.
      blink_gate   = blink_phase ? '1 : ~blink_mask;
      unused_wdata = ^writedata[31:18];
   end

   // Step prescaler and PWM position counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prescaler <= '0;
         pwm_cnt   <= '0;
      end else begin
         if (step_tick) begin
            prescaler <= '0;
            pwm_cnt   <= pwm_cnt + 8'd1;
         end else begin
            prescaler <= prescaler + 16'd1;
         end
      end
   end

   // Duty: shadow updates at once, active copy only at frame end. A write
   // landing on the frame-end edge is forwarded straight into the active copy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         duty_shadow <= 8'hFF;
         active_duty <= 8'hFF;
      end else begin
         if (wr_duty) begin
            duty_shadow <= writedata[7:0];
         end
         if (frame_end) begin
            active_duty <= wr_duty ? writedata[7:0] : duty_shadow;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_mask   <= '0;
         blink_period <= '0;
      end else begin
         if (wr_mask) begin
            blink_mask <= writedata[17:0];
         end
         if (wr_period) begin
            blink_period <= writedata[15:0];
         end
      end
   end

   // Blink engine. A period write restarts the blink cycle and takes
   // priority over a coincident frame end.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (wr_period) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (frame_end && (blink_period != 16'd0)) begin
         if (frame_cnt == (blink_period - 16'd1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_out <= '0;
      end else begin
         led_out <= led_in & {18{pwm_on}} & blink_gate;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0: readdata[7:0]   = duty_shadow;
         2'd1: readdata[17:0]  = blink_mask;
         2'd2: readdata[15:0]  = blink_period;
         default: begin
            readdata[0]    = blink_phase;
            readdata[15:8] = pwm_cnt;
         end
      endcase
   end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver. The reference model derives the PWM position and
// frame boundaries from the cycle count since reset release, and the blink
// phase from the number of completed frames since the last period write.
module tb_led_pwm_driver;

   localparam int P = 2;
   localparam int F = 256 * P;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [17:0] led_in;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [17:0] led_out;

   int n_tests = 0;
   int n_fail  = 0;

   logic [17:0] led_q[$];
   logic [31:0] rd_q[$];

   // Model state
   int          t;
   int          pw_t;
   logic [7:0]  m_sh;
   logic [7:0]  m_act;
   logic [17:0] m_mask;
   logic [15:0] m_per;

   led_pwm_driver #(.PRESCALE(P)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .led_in     (led_in),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .led_out    (led_out)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] m_cnt();
      return 8'((t / P) % 256);
   endfunction

   function automatic bit m_phase();
      int frames;
      if (m_per == 16'd0) return 1'b1;
      frames = (t / F) - ((pw_t + 1) / F);
      return ((frames / int'(m_per)) % 2) == 0;
   endfunction

   function automatic bit m_on();
      return (m_act == 8'hFF) || (m_cnt() < m_act);
   endfunction

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return {24'h0, m_sh};
         2'd1:    return {14'h0, m_mask};
         2'd2:    return {16'h0, m_per};
         default: return {16'h0, m_cnt(), 7'h0, m_phase()};
      endcase
   endfunction

   task automatic model_reset();
      t      = 0;
      pw_t   = -1;
      m_sh   = 8'hFF;
      m_act  = 8'hFF;
      m_mask = '0;
      m_per  = '0;
   endtask

   // One clock of stimulus: drive at negedge, queue expectations, advance model.
   task automatic drive_cycle(input bit rst, input bit do_wr, input logic [1:0] a,
                              input logic [31:0] wd, input logic [17:0] li);
      logic [17:0] gate;
      int r;
      bit fe;
      @(negedge clk);
      reset_n = !rst;
      led_in  = li;
      address = a;
      if (do_wr) begin
         chipselect = 1'b1;
         write_n    = 1'b0;
         writedata  = wd;
      end else begin
         r = $urandom_range(0, 2);
         chipselect = (r == 2);
         write_n    = (r != 0);
         writedata  = $urandom;
      end
      if (rst) begin
         led_q.push_back(18'h0);
         model_reset();
         return;
      end
      gate = m_phase() ? 18'h3FFFF : ~m_mask;
      led_q.push_back(li & {18{m_on()}} & gate);
      rd_q.push_back(m_read(a));
      fe = ((t + 1) % F) == 0;
      if (do_wr) begin
         case (a)
            2'd0: m_sh = wd[7:0];
            2'd1: m_mask = wd[17:0];
            2'd2: begin
               m_per = wd[15:0];
               pw_t  = t;
            end
            default: ;
         endcase
      end
      if (fe) m_act = m_sh;
      t++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive_cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), 32'h0, 18'($urandom));
   endtask

   task automatic idle_led(input int n, input logic [17:0] li);
      for (int i = 0; i < n; i++)
         drive_cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), 32'h0, li);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      drive_cycle(1'b0, 1'b1, a, d, 18'($urandom));
   endtask

   // Monitors
   always @(posedge clk) begin
      logic [17:0] e;
      #1;
      if (led_q.size() > 0) begin
         e = led_q.pop_front();
         n_tests++;
         if (led_out !== e) begin
            n_fail++;
            $display("FAIL led_out @%0t: got %h, expected %h", $time, led_out, e);
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0] e;
      #2;
      if (rd_q.size() > 0) begin
         e = rd_q.pop_front();
         n_tests++;
         if (readdata !== e) begin
            n_fail++;
            $display("FAIL readdata addr=%0d @%0t: got %h, expected %h",
                     address, $time, readdata, e);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int guard;
      reset_n    = 1'b0;
      led_in     = '0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      model_reset();

      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 2'd3, 32'h0, 18'h2AAAA);
      // Transparent after release, STATUS phase bit set.
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 2'd3, 32'h0, 18'h2AAAA);
      idle(20);

      // Duty 64, full frames.
      wr(2'd0, 32'd64);
      idle_led(1500, 18'h3FFFF);

      // Duty 200 written mid-frame.
      guard = 0;
      while ((t % F) != 100 && guard < F) begin
         idle_led(1, 18'h3FFFF);
         guard++;
      end
      wr(2'd0, 32'hDEAD_BEC8);
      idle_led(1100, 18'h3FFFF);

      // Blink on bit 0 only.
      wr(2'd0, 32'd255);
      wr(2'd1, 32'h0000_0001);
      wr(2'd2, 32'd2);
      idle_led(2600, 18'h3FFFF);

      // Period write exactly on a frame-end cycle.
      guard = 0;
      while (((t + 1) % F) != 0 && guard < F) begin
         idle_led(1, 18'h3FFFF);
         guard++;
      end
      wr(2'd2, 32'h0001_0003);
      idle_led(700, 18'h3FFFF);

      // Duty 0 -> dark.
      wr(2'd0, 32'd0);
      idle(1100);

      // Randomized register traffic.
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            d = $urandom;
            case ($urandom_range(0, 3))
               0: d[15:0] = 16'($urandom_range(0, 3));
               1: d[7:0]  = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
               default: ;
            endcase
            wr(2'($urandom_range(0, 3)), d);
         end else begin
            idle(1);
         end
      end

      // Reset asserted in the off phase at pwm_cnt 130.
      wr(2'd0, 32'd255);
      wr(2'd1, 32'h0003_FFFF);
      wr(2'd2, 32'd1);
      guard = 0;
      while (!(!m_phase() && m_cnt() == 8'd130) && guard < 4 * F) begin
         idle_led(1, 18'h3FFFF);
         guard++;
      end
      n_tests++;
      if (guard >= 4 * F) begin
         n_fail++;
         $display("FAIL blink_wait: got no off-phase at cnt 130, expected one within %0d cycles", 4 * F);
      end
      drive_cycle(1'b1, 1'b0, 2'd3, 32'h0, 18'h3FFFF);
      drive_cycle(1'b1, 1'b0, 2'd3, 32'h0, 18'h3FFFF);
      for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 2'd3, 32'h0, 18'h3FFFF);
      idle(50);

      @(negedge clk);
      address    = 2'd3;
      chipselect = 1'b0;
      write_n    = 1'b1;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
